// File: rtl/drive_ctrl.sv
// Drive controller: start/move/stop sequencing from the pedal levels,
// a direction latch taken when the vehicle starts moving, and a saturating
// mileage counter advanced by a prescaler that only runs while moving.
//
// state           | meaning
// ----------------+------------------------------------------------
// ST_NOT_STARTING | idle / braked / unpowered; prescaler held at 0
// ST_STARTING     | clutch engaged, ready to pull away
// ST_MOVING       | driving; prescaler counts towards mileage ticks
// ST_ILLEGAL      | never produced; recovers to ST_NOT_STARTING
module drive_ctrl #(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned MILEAGE_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 power,
    input  logic                 clutch,
    input  logic                 throttle,
    input  logic                 brake,
    input  logic                 reverse,
    output logic [1:0]           state,
    output logic                 dir,
    output logic [MILEAGE_W-1:0] mileage,
    output logic                 mileage_tick
);

    typedef enum logic [1:0] {
        ST_NOT_STARTING = 2'b00,
        ST_STARTING     = 2'b01,
        ST_MOVING       = 2'b10,
        ST_ILLEGAL      = 2'b11
    } state_e;

    localparam logic [31:0]          PRESC_MAX   = 32'(TICK_DIV - 1);
    localparam logic [MILEAGE_W-1:0] MILEAGE_MAX = '1;
    localparam logic [MILEAGE_W-1:0] MILEAGE_ONE = MILEAGE_W'(1);

    state_e                 state_q, state_d;
    logic                   dir_q, dir_d;
    logic [31:0]            presc_q, presc_d;
    logic [MILEAGE_W-1:0]   mileage_q, mileage_d;
    logic                   tick_q, tick_d;

    // State, direction, prescaler and mileage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_NOT_STARTING;
            dir_q     <= 1'b0;
            presc_q   <= '0;
            mileage_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            presc_q   <= presc_d;
            mileage_q <= mileage_d;
            tick_q    <= tick_d;
        end
    end

    // Next-state: power loss clears everything except dir, brake beats pedals,
    // prescaler follows the registered state so the wrap edge is well defined
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        presc_d   = presc_q;
        mileage_d = mileage_q;
        tick_d    = 1'b0;

        if (!power) begin
            state_d   = ST_NOT_STARTING;
            presc_d   = '0;
            mileage_d = '0;
        end else begin
            if (state_q == ST_MOVING) begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (mileage_q != MILEAGE_MAX) begin
                        mileage_d = mileage_q + MILEAGE_ONE;
                    end
                end else begin
                    presc_d = presc_q + 32'd1;
                end
            end else begin
                presc_d = '0;
            end

            if (brake) begin
                state_d = ST_NOT_STARTING;
            end else begin
                case (state_q)
                    ST_NOT_STARTING: begin
                        if (clutch && throttle) state_d = ST_STARTING;
                    end
                    ST_STARTING: begin
                        if (!clutch && throttle) begin
                            state_d = ST_MOVING;
                            dir_d   = reverse;
                        end
                    end
                    ST_MOVING: begin
                        if (clutch || !throttle) state_d = ST_STARTING;
                    end
                    default: state_d = ST_NOT_STARTING;
                endcase
            end
        end
    end

    assign state        = state_q;
    assign dir          = dir_q;
    assign mileage      = mileage_q;
    assign mileage_tick = tick_q;

endmodule

// File: tb/tb_drive_ctrl.sv
// Bench for drive_ctrl with TICK_DIV=4, MILEAGE_W=4: directed scenarios with
// literal expectations, then randomized pedal/power/reset traffic against a
// cycle-level behavioural model.
module tb_drive_ctrl;

    localparam int TD   = 4;
    localparam int MW   = 4;
    localparam int MMAX = (1 << MW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          power = 1'b0, clutch = 1'b0, throttle = 1'b0, brake = 1'b0, reverse = 1'b0;
    logic [1:0]    state;
    logic          dir;
    logic [MW-1:0] mileage;
    logic          mileage_tick;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // model: phase 0 idle, 1 starting, 2 moving; moving_cycles counts edges spent moving
    int m_phase = 0;
    int m_dir = 0;
    int m_moving_cycles = 0;
    int m_mileage = 0;
    int m_tick = 0;

    drive_ctrl #(.TICK_DIV(TD), .MILEAGE_W(MW)) dut (
        .clk(clk), .rst_n(rst_n), .power(power), .clutch(clutch),
        .throttle(throttle), .brake(brake), .reverse(reverse),
        .state(state), .dir(dir), .mileage(mileage), .mileage_tick(mileage_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. A tick is due when the number of edges spent in the
    // moving phase reaches a multiple of TD; power loss wipes the odometer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_dir = 0; m_moving_cycles = 0; m_mileage = 0; m_tick = 0;
        end else if (!power) begin
            m_phase = 0; m_moving_cycles = 0; m_mileage = 0; m_tick = 0;
        end else begin
            int nxt;
            m_tick = 0;
            if (m_phase == 2) begin
                m_moving_cycles++;
                if (m_moving_cycles % TD == 0) begin
                    m_tick = 1;
                    m_mileage = (m_mileage + 1 > MMAX) ? MMAX : m_mileage + 1;
                end
            end else begin
                m_moving_cycles = 0;
            end
            nxt = m_phase;
            if (brake) nxt = 0;
            else if (m_phase == 0 && clutch && throttle) nxt = 1;
            else if (m_phase == 1 && !clutch && throttle) begin
                nxt = 2;
                m_dir = int'(reverse);
            end
            else if (m_phase == 2 && (clutch || !throttle)) nxt = 1;
            if (nxt == 2 && m_phase != 2) m_moving_cycles = 0;
            m_phase = nxt;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_state", int'(state), m_phase);
            chk("model_dir", int'(dir), m_dir);
            chk("model_mileage", int'(mileage), m_mileage);
            chk("model_tick", int'(mileage_tick), m_tick);
        end
    end

    task automatic cyc(input bit p, input bit c, input bit t, input bit b, input bit r);
        power = p; clutch = c; throttle = t; brake = b; reverse = r;
        @(negedge clk);
    endtask

    initial begin
        int ticks;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_dir", int'(dir), 0);
        chk("reset_mileage", int'(mileage), 0);
        chk("reset_tick", int'(mileage_tick), 0);
        rst_n = 1'b1;
        check_en = 1'b1;

        // start then move forward
        cyc(1, 1, 1, 0, 0); chk("start_01", int'(state), 1);
        cyc(1, 0, 1, 0, 0); chk("move_10", int'(state), 2); chk("dir_fwd", int'(dir), 0);
        cyc(1, 1, 1, 0, 0); chk("back_01", int'(state), 1);
        cyc(1, 1, 1, 0, 1); chk("hold_01", int'(state), 1);
        cyc(1, 0, 1, 0, 1); chk("move_rev", int'(state), 2); chk("dir_rev", int'(dir), 1);
        cyc(1, 0, 1, 0, 0); chk("rev_toggle_state", int'(state), 2); chk("rev_toggle_dir", int'(dir), 1);

        // fresh power cycle, 12 moving cycles -> three ticks
        cyc(0, 0, 1, 0, 0); chk("pwr_off_state", int'(state), 0);
        chk("pwr_off_mileage", int'(mileage), 0); chk("pwr_off_dir_hold", int'(dir), 1);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0); chk("move2", int'(state), 2); chk("dir_fwd2", int'(dir), 0);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 1, 0, 0);
            chk("tick_every_4", int'(mileage_tick), (i % 4 == 3) ? 1 : 0);
        end
        chk("mileage_3", int'(mileage), 3);
        cyc(1, 1, 1, 0, 0); chk("clutch_01", int'(state), 1); chk("mileage_hold", int'(mileage), 3);

        // brake priority
        cyc(1, 1, 1, 1, 0); chk("brake_from_01", int'(state), 0);
        cyc(1, 1, 1, 1, 0); chk("brake_in_00", int'(state), 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0); chk("move3", int'(state), 2);
        cyc(1, 1, 1, 1, 0); chk("brake_from_10", int'(state), 0); chk("brake_mileage_hold", int'(mileage), 3);

        // power drop on the wrap edge
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        repeat (3) cyc(1, 0, 1, 0, 0);
        chk("prewrap_mileage", int'(mileage), 3); chk("prewrap_tick", int'(mileage_tick), 0);
        cyc(0, 0, 1, 0, 0);
        chk("drop_wrap_mileage", int'(mileage), 0); chk("drop_wrap_tick", int'(mileage_tick), 0);
        chk("drop_wrap_state", int'(state), 0);

        // saturation over 80 moving cycles
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        ticks = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1, 0, 1, 0, 0);
            ticks += int'(mileage_tick);
        end
        chk("sat_mileage", int'(mileage), 15);
        chk("sat_tick_count", ticks, 20);
        chk("sat_last_tick", int'(mileage_tick), 1);
        repeat (2) cyc(1, 0, 1, 0, 0);

        // asynchronous reset mid-count
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_dir", int'(dir), 0);
        chk("async_mileage", int'(mileage), 0);
        chk("async_tick", int'(mileage_tick), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_tick", int'(mileage_tick), 0);
            chk("post_rst_state", int'(state), 0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk); #2 rst_n = 1'b1;
            end else begin
                cyc($urandom_range(0, 99) < 97,
                    $urandom_range(0, 99) < 40,
                    $urandom_range(0, 99) < 80,
                    $urandom_range(0, 99) < 4,
                    $urandom_range(0, 1) == 1);
            end
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/drive_ctrl.md
DRIVE_CTRL -- requirements
Module: drive_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per mileage unit (1 s at 100 MHz); legal range 2..2^32-1.
REQ-002 The block SHALL have parameter MILEAGE_W, default 32, meaning the width of the mileage counter.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port power  input  1  engine power-on flag from the upstream power controller.
REQ-006 The block SHALL have port clutch  input  1  clutch pedal pressed, level.
REQ-007 The block SHALL have port throttle  input  1  throttle pressed, level.
REQ-008 The block SHALL have port brake  input  1  brake pressed, level.
REQ-009 The block SHALL have port reverse  input  1  reverse gear selected, level.
REQ-010 The block SHALL have port state  output  2  driving state (00 NOT_STARTING, 01 STARTING, 10 MOVING) fed back to the power controller.
REQ-011 The block SHALL have port dir  output  1  latched travel direction (0 forward, 1 backward).
REQ-012 The block SHALL have port mileage  output  MILEAGE_W  accumulated mileage units since power-on.
REQ-013 The block SHALL have port mileage_tick  output  1  one-cycle pulse per mileage increment.

Function
REQ-014 All outputs SHALL be registered; every input change SHALL take effect at the next rising clk edge (one-cycle latency).
REQ-015 If power=0, state SHALL become 00, mileage SHALL become 0 and the prescaler SHALL become 0 on the next edge, overriding all other conditions; dir SHALL hold.
REQ-016 With power=1 and brake=1, state SHALL become 00 from any state (brake priority over clutch/throttle).
REQ-017 In 00 with power=1, brake=0, clutch=1, throttle=1, state SHALL become 01; otherwise it SHALL stay 00.
REQ-018 In 01 with brake=0, clutch=0, throttle=1, state SHALL become 10 and dir SHALL load reverse on the same edge; otherwise it SHALL stay 01.
REQ-019 In 10 with brake=0, clutch=1 or throttle=0 SHALL return state to 01; otherwise it SHALL stay 10.
REQ-020 Encoding 11 SHALL never be produced; if reached, the next edge SHALL force 00.
REQ-021 dir SHALL change only on the 01->10 transition; toggling reverse while in 10 SHALL NOT alter dir or state (stall handling belongs to the power controller).
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 only while state=10 and SHALL be forced to 0 on any edge where the registered state is not 10.
REQ-023 When the prescaler is at TICK_DIV-1 with state=10, it SHALL wrap to 0, mileage_tick SHALL be 1 for exactly that following cycle and mileage SHALL increment by 1.
REQ-024 mileage SHALL saturate at 2^MILEAGE_W-1; mileage_tick SHALL still pulse at saturation.
REQ-025 If a power drop coincides with a prescaler wrap, clearing SHALL win: mileage=0 and mileage_tick=0.
REQ-026 mileage SHALL be held, not cleared, across transitions to 00 or 01 while power=1.

Reset
REQ-027 On rst_n=0, asynchronously: state=00, dir=0, mileage=0, mileage_tick=0, prescaler=0.
REQ-028 Deassertion of rst_n mid-operation SHALL resume from reset values at the first following edge with no spurious mileage_tick.

Verification
REQ-029 Bench SHALL run with TICK_DIV=4, MILEAGE_W=4.
REQ-030 Reset, power=1, clutch=1, throttle=1 -> state 00->01 one edge later; then clutch=0 -> state=10, dir=0.
REQ-031 In 01 with reverse=1, release clutch -> state=10, dir=1; toggle reverse to 0 in 10 -> dir stays 1, state stays 10.
REQ-032 Hold state=10 for 12 cycles -> mileage_tick pulses every 4th cycle, mileage=3; clutch=1 -> state=01, mileage holds 3.
REQ-033 brake=1 together with clutch=1, throttle=1 in any state -> state=00; power=0 at a prescaler wrap -> mileage=0, no tick.
REQ-034 Hold 10 for 80 cycles -> mileage saturates at 15, ticks continue; assert rst_n=0 mid-count -> all outputs zero immediately, no glitch pulse after release.
